// File: rtl/guess_history_pkg.sv
// Shared sizes and peg/guess types for the turn-history store.
// Optional feature macro used by guess_history: HISTORY_WRAP_EN.
package guess_history_pkg;

    localparam int NUM_PEGS  = 4;
    localparam int PEG_W     = 3;
    localparam int MAX_TURNS = 8;
    localparam int TURN_W    = 3;
    localparam int COUNT_W   = TURN_W + 1;

    typedef logic [PEG_W-1:0]              peg_t;
    typedef peg_t [NUM_PEGS-1:0]           guess_t;
    typedef logic [TURN_W-1:0]             turn_t;
    typedef logic [COUNT_W-1:0]            count_t;

    function automatic guess_t pack_guess(input peg_t p0, input peg_t p1,
                                          input peg_t p2, input peg_t p3);
        guess_t g;
        g[0] = p0;
        g[1] = p1;
        g[2] = p2;
        g[3] = p3;
        return g;
    endfunction

endpackage

// File: rtl/guess_history_btn_edge.sv
// Single-bit rising-edge detector: pulses for the cycle a level first reads 1
// after having been 0 on the previous clock.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/guess_history.sv
// Turn-history store: records up to 8 committed guesses and lets the player
// browse them. Define HISTORY_WRAP_EN to make browsing wrap around.
module guess_history
    import guess_history_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_select,
    input  logic [PEG_W-1:0] guess0,
    input  logic [PEG_W-1:0] guess1,
    input  logic [PEG_W-1:0] guess2,
    input  logic [PEG_W-1:0] guess3,
    output logic [PEG_W-1:0] selection0,
    output logic [PEG_W-1:0] selection1,
    output logic [PEG_W-1:0] selection2,
    output logic [PEG_W-1:0] selection3,
    output logic [TURN_W-1:0] selected_turn,
    output logic             end_game
);

    logic   w_up_rise;
    logic   w_dn_rise;
    logic   w_sel_rise;

    guess_t r_mem [MAX_TURNS];
    count_t r_count;
    turn_t  r_ptr;
    logic   r_end_game;

    guess_t w_guess;
    guess_t w_sel_guess;
    count_t w_count_m1;
    turn_t  w_last;
    turn_t  w_ptr_nxt;
    logic   w_full;
    logic   w_empty;
    logic   w_commit;
    logic   w_nav;
    logic   w_at_top;

    btn_edge u_edge_up (
        .clk    (clk),
        .rst_n  (reset),
        .i_btn  (btn_up),
        .o_rise (w_up_rise)
    );

    btn_edge u_edge_down (
        .clk    (clk),
        .rst_n  (reset),
        .i_btn  (btn_down),
        .o_rise (w_dn_rise)
    );

    btn_edge u_edge_select (
        .clk    (clk),
        .rst_n  (reset),
        .i_btn  (btn_select),
        .o_rise (w_sel_rise)
    );

    assign w_guess    = pack_guess(guess0, guess1, guess2, guess3);
    assign w_full     = (r_count == count_t'(MAX_TURNS));
    assign w_empty    = (r_count == '0);
    assign w_count_m1 = r_count - count_t'(1);
    assign w_last     = w_count_m1[TURN_W-1:0];
    assign w_at_top   = ({1'b0, r_ptr} == w_count_m1);

    // Opposing edges in one cycle cancel; an empty history ignores browsing.
    assign w_commit = ~mode & w_sel_rise & ~w_full;
    assign w_nav    = mode & ~w_empty & (w_up_rise ^ w_dn_rise);

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_commit) begin
            w_ptr_nxt = r_count[TURN_W-1:0];
        end else if (w_nav) begin
            if (w_up_rise) begin
                if (!w_at_top) begin
                    w_ptr_nxt = r_ptr + turn_t'(1);
                end else begin
`ifdef HISTORY_WRAP_EN
                    w_ptr_nxt = '0;
`else
                    w_ptr_nxt = r_ptr;
`endif
                end
            end else begin
                if (r_ptr != '0) begin
                    w_ptr_nxt = r_ptr - turn_t'(1);
                end else begin
`ifdef HISTORY_WRAP_EN
                    w_ptr_nxt = w_last;
`else
                    w_ptr_nxt = r_ptr;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_ptr      <= '0;
            r_end_game <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_commit) begin
                r_count <= r_count + count_t'(1);
                if (r_count == count_t'(MAX_TURNS - 1)) begin
                    r_end_game <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_TURNS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_count[TURN_W-1:0]] <= w_guess;
        end
    end

    assign w_sel_guess   = w_empty ? '0 : r_mem[r_ptr];
    assign selection0    = w_sel_guess[0];
    assign selection1    = w_sel_guess[1];
    assign selection2    = w_sel_guess[2];
    assign selection3    = w_sel_guess[3];
    assign selected_turn = r_ptr;
    assign end_game      = r_end_game;

endmodule

// File: tb/tb_guess_history.sv
// Directed and randomized bench for guess_history against a behavioural
// model of the turn history (arrays plus counters).
module tb_guess_history;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_select = 1'b0;
    logic [2:0] guess0 = '0;
    logic [2:0] guess1 = '0;
    logic [2:0] guess2 = '0;
    logic [2:0] guess3 = '0;
    logic [2:0] selection0;
    logic [2:0] selection1;
    logic [2:0] selection2;
    logic [2:0] selection3;
    logic [2:0] selected_turn;
    logic       end_game;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit [2:0] m_mem [8][4];
    int       m_count;
    int       m_ptr;
    bit       m_end;
    bit       m_prev_up, m_prev_dn, m_prev_sel;

    guess_history dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_select    (btn_select),
        .guess0        (guess0),
        .guess1        (guess1),
        .guess2        (guess2),
        .guess3        (guess3),
        .selection0    (selection0),
        .selection1    (selection1),
        .selection2    (selection2),
        .selection3    (selection3),
        .selected_turn (selected_turn),
        .end_game      (end_game)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int t = 0; t < 8; t++)
            for (int p = 0; p < 4; p++)
                m_mem[t][p] = 3'd0;
        m_count = 0;
        m_ptr = 0;
        m_end = 1'b0;
        m_prev_up = 1'b0;
        m_prev_dn = 1'b0;
        m_prev_sel = 1'b0;
    endtask

    task automatic model_step();
        bit up_e, dn_e, sel_e;
        up_e = btn_up && !m_prev_up;
        dn_e = btn_down && !m_prev_dn;
        sel_e = btn_select && !m_prev_sel;
        m_prev_up = btn_up;
        m_prev_dn = btn_down;
        m_prev_sel = btn_select;
        if (!mode) begin
            if (sel_e && m_count < 8) begin
                m_mem[m_count][0] = guess0;
                m_mem[m_count][1] = guess1;
                m_mem[m_count][2] = guess2;
                m_mem[m_count][3] = guess3;
                m_ptr = m_count;
                m_count++;
                if (m_count == 8) m_end = 1'b1;
            end
        end else if (m_count > 0 && (up_e != dn_e)) begin
            if (up_e) begin
                if (m_ptr + 1 < m_count) m_ptr++;
`ifdef HISTORY_WRAP_EN
                else m_ptr = 0;
`endif
            end else begin
                if (m_ptr > 0) m_ptr--;
`ifdef HISTORY_WRAP_EN
                else m_ptr = m_count - 1;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int e0, e1, e2, e3;
        e0 = (m_count > 0) ? int'(m_mem[m_ptr][0]) : 0;
        e1 = (m_count > 0) ? int'(m_mem[m_ptr][1]) : 0;
        e2 = (m_count > 0) ? int'(m_mem[m_ptr][2]) : 0;
        e3 = (m_count > 0) ? int'(m_mem[m_ptr][3]) : 0;
        chk({tag, ".sel0"}, int'(selection0), e0);
        chk({tag, ".sel1"}, int'(selection1), e1);
        chk({tag, ".sel2"}, int'(selection2), e2);
        chk({tag, ".sel3"}, int'(selection3), e3);
        chk({tag, ".turn"}, int'(selected_turn), m_ptr);
        chk({tag, ".end"}, int'(end_game), int'(m_end));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit m, input bit u, input bit d, input bit s);
        mode = m;
        btn_up = u;
        btn_down = d;
        btn_select = s;
    endtask

    task automatic set_guess(input int a, input int b, input int c, input int d);
        guess0 = 3'(a);
        guess1 = 3'(b);
        guess2 = 3'(c);
        guess3 = 3'(d);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic commit(input int a, input int b, input int c, input int d, input string tag);
        set_guess(a, b, c, d);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle({tag, ".rel"});
    endtask

    task automatic pulse(input bit m, input bit u, input bit d, input bit s, input string tag);
        drive(m, u, d, s);
        cycle(tag);
        drive(m, 1'b0, 1'b0, 1'b0);
        cycle({tag, ".rel"});
    endtask

    initial begin
        model_reset();
        do_reset("reset_state");

        // Down held in browse with empty history
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("empty_down");
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        cycle("empty_up_sel");

        // First commit, then hold select
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("idle");
        set_guess(1, 1, 1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        cycle("first_commit");
        set_guess(5, 5, 5, 5);
        for (int i = 0; i < 3; i++) cycle("hold_select");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("hold_release");
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "count_is_one_up");

        // Browse navigation
        do_reset("reset_nav");
        commit(1, 1, 1, 1, "nav_c1");
        commit(2, 2, 2, 2, "nav_c2");
        commit(3, 3, 3, 3, "nav_c3");
        pulse(1'b1, 1'b0, 1'b1, 1'b0, "nav_down1");
        pulse(1'b1, 1'b0, 1'b1, 1'b0, "nav_down2");
        pulse(1'b1, 1'b0, 1'b1, 1'b0, "nav_down_floor");
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "nav_up1");
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "nav_up2");
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "nav_up3");

        // Ignored / simultaneous events
        pulse(1'b1, 1'b0, 1'b1, 1'b0, "pre_ign_down");
        pulse(1'b1, 1'b1, 1'b1, 1'b0, "up_down_same");
        set_guess(6, 6, 6, 6);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, "select_in_browse");
        pulse(1'b0, 1'b1, 1'b0, 1'b0, "up_in_entry");
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "down_in_entry");

        // Fill to end
        do_reset("reset_fill");
        for (int t = 0; t < 8; t++)
            commit($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7), "fill");
        commit(7, 6, 5, 4, "ninth_select");
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, 1'b1, 1'b0, "full_browse_down");
        pulse(1'b1, 1'b0, 1'b1, 1'b0, "full_down_floor");
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "full_up");

        // Reset mid-game
        do_reset("reset_mid_pre");
        for (int t = 0; t < 5; t++) commit(t, t + 1, t + 2, 7 - t, "mid_fill");
        do_reset("reset_mid");
        commit(4, 3, 2, 1, "post_reset_commit");

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299) do_reset("rand_reset");
            if ($urandom_range(9) == 0) mode = ~mode;
            btn_up = ($urandom_range(3) == 0);
            btn_down = ($urandom_range(3) == 0);
            btn_select = ($urandom_range(2) == 0);
            set_guess($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_history.md
# guess_history

Turn-history store for the code-breaking game. In entry mode it records each submitted 4-peg guess (3-bit colour per peg) into the next free turn slot, up to 8 turns, and flags end of game when full. In browse mode the player steps through recorded turns with up/down buttons, and the stored pegs of the selected turn drive the display path.

## Interface
- Parameters: none; sizes come from shared package constants.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = entry, 1 = browse.
- btn_up  in  1  level from debounced button; browse to the newer turn.
- btn_down  in  1  level; browse to the older turn.
- btn_select  in  1  level; commit the current guess (entry mode).
- guess0..guess3  in  3 each  pegs of the guess being committed.
- selection0..selection3  out  3 each  pegs of the selected turn.
- selected_turn  out  3  index of the selected turn (0 = first).
- end_game  out  1  high once 8 turns are recorded.

## Operation
- Each button passes through a rising-edge detector (previous-sample register). An action fires only on the first cycle the button is sampled 1 after being 0. Holding a button produces one action.
- State:
  - mem[0..7][0..3], 3 bits per peg.
  - count, 0..8 (4 bits).
  - ptr, 3 bits.
  - end_game register.
- Entry mode (mode=0):
  - Select edge with count<8: mem[count] <= guess0..3, ptr <= count, count <= count+1.
  - If the new count is 8, end_game <= 1.
  - Up/down edges are ignored.
- Browse mode (mode=1):
  - Up edge: if ptr+1 < count, ptr <= ptr+1; otherwise no change.
  - Down edge: if ptr > 0, ptr <= ptr-1; otherwise no change.
  - Up and down edges in the same cycle: no change.
  - Select edge is ignored.
  - With count=0, every button is a no-op.
- Select with count=8: ignored, state frozen until reset.
- Outputs are combinational from registers:
  - selection = mem[ptr] when count>0, otherwise all zeros.
  - selected_turn = ptr.
- Reset, including mid-game: count=0, ptr=0, end_game=0, edge registers=0, mem cleared to 0. All outputs therefore read 0.
- A mode change takes effect the same cycle. ptr is kept across mode changes.

## Timing
- An action on clock edge N (button rising edge sampled at edge N) produces updated outputs after edge N, with zero additional latency.
- end_game asserts after the edge that stores turn 8 and stays high until reset.
- Asynchronous reset clears state immediately. Release is synchronised externally.

## Configuration
- HISTORY_WRAP_EN defined:
  - Browse wraps around the recorded range.
  - Up at ptr=count-1 goes to 0; down at ptr=0 goes to count-1.
  - count=0 is still a no-op.
- HISTORY_WRAP_EN undefined: saturating behaviour as in Operation.

## Structure
- Shared package holds:
  - NUM_PEGS=4
  - PEG_W=3
  - MAX_TURNS=8
  - TURN_W=3
  - the peg/guess typedefs
- One sub-module, btn_edge (single-bit rising-edge detector with async active-low reset), instantiated three times.
- The memory is a flat register array; no RAM macro is used.

## Test plan
- Down in browse mode with empty history:
  - Stimulus: reset, mode=1, btn_down=1 held.
  - Response: selected_turn=0, selection=0-0-0-0, end_game=0, no change for several cycles.
- First commit:
  - Stimulus: mode=0, guess=1-1-1-1, btn_select rises.
  - Response: next cycle selection=1-1-1-1, selected_turn=0, end_game=0.
  - Holding select and staying in mode=0 records nothing further (count stays 1).
- Browse navigation:
  - Stimulus: commit 3 guesses (1-1-1-1, 2-2-2-2, 3-3-3-3), then mode=1, two down pulses, then three up pulses.
  - Response: selected_turn goes 2→1→0, then 1→2→2; selection tracks mem.
- Fill to end:
  - Stimulus: commit 8 guesses.
  - Response: end_game=1 after the 8th; a 9th select leaves selected_turn=7 and mem unchanged.
- Simultaneous/ignored events:
  - Stimulus: up and down edges in the same cycle; select in mode=1; up in mode=0.
  - Response: no state change.
- Reset mid-game:
  - Stimulus: after 5 turns, pulse reset low.
  - Response: all outputs 0 immediately; the next commit lands in turn 0.
